// File: rtl/gsim_result_drain_if.sv
// Interface for the result drain: solver-side word input and the
// backpressured output stream, plus frame status.
interface gsim_result_drain_if #(
  parameter int DW = 32,
  parameter int IW = 4
);
  localparam int SW = DW + IW;

  logic          x_valid;
  logic [DW-1:0] x_in;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [15:0]   m_int;
  logic [IW-1:0] m_index;
  logic          m_last;
  logic [SW-1:0] frame_sum;
  logic          busy;
  logic          overrun;

  modport master (
    output x_valid, x_in, m_ready,
    input  m_valid, m_data, m_int, m_index, m_last, frame_sum, busy, overrun
  );

  modport slave (
    input  x_valid, x_in, m_ready,
    output m_valid, m_data, m_int, m_index, m_last, frame_sum, busy, overrun
  );
endinterface

// File: rtl/gsim_result_drain.sv
// Captures a DEPTH-word Q16.16 solution burst, then replays it on a
// valid/ready stream with a rounded/saturated integer view and frame sum.
module gsim_result_drain #(
  parameter int DEPTH = 16,
  parameter int DW    = 32
) (
  input  logic               clk,
  input  logic               reset,
  gsim_result_drain_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int SW = DW + IW;
  localparam int FB = 16;
  localparam logic signed [DW:0] HALF = (DW+1)'(1) << (FB-1);
  localparam logic signed [DW:0] IMAX = (DW+1)'(32767);
  localparam logic signed [DW:0] IMIN = (DW+1)'(-32768);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

  state_t                r_state;
  logic [DW-1:0]         r_buf [DEPTH];
  logic [IW-1:0]         r_wcnt;
  logic [IW-1:0]         r_rptr;
  logic signed [SW-1:0]  r_acc;
  logic signed [SW-1:0]  r_sum;
  logic                  r_mvalid;
  logic                  r_busy;
  logic                  r_overrun;

  logic                  w_wr;
  logic                  w_hs;
  logic                  w_last;
  logic signed [SW-1:0]  w_ext;
  logic signed [SW-1:0]  w_acc_nxt;
  logic [DW-1:0]         w_data;
  logic signed [DW:0]    w_t;
  logic signed [DW:0]    w_sh;
  logic [15:0]           w_int;

  assign w_wr      = bus.x_valid && (r_state != DRAIN);
  assign w_hs      = r_mvalid && bus.m_ready;
  assign w_last    = (r_rptr == IW'(DEPTH-1));
  assign w_ext     = {{IW{bus.x_in[DW-1]}}, bus.x_in};
  assign w_acc_nxt = (r_state == IDLE) ? w_ext : r_acc + w_ext;

  // Storage is not reset; the write count is 0 in IDLE so one index serves both states.
  always_ff @(posedge clk) begin
    if (w_wr) r_buf[r_wcnt] <= bus.x_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_wcnt    <= '0;
      r_rptr    <= '0;
      r_acc     <= '0;
      r_sum     <= '0;
      r_mvalid  <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (bus.x_valid) begin
          r_wcnt  <= IW'(1);
          r_acc   <= w_acc_nxt;
          r_busy  <= 1'b1;
          r_state <= FILL;
        end
        FILL: if (bus.x_valid) begin
          r_wcnt <= r_wcnt + 1'b1;
          r_acc  <= w_acc_nxt;
          if (r_wcnt == IW'(DEPTH-1)) begin
            r_sum    <= w_acc_nxt;
            r_rptr   <= '0;
            r_mvalid <= 1'b1;
            r_state  <= DRAIN;
          end
        end
        DRAIN: begin
          // Words arriving while the frame is still draining are lost.
          if (bus.x_valid) r_overrun <= 1'b1;
          if (w_hs) begin
            r_rptr <= r_rptr + 1'b1;
            if (w_last) begin
              r_mvalid <= 1'b0;
              r_busy   <= 1'b0;
              r_state  <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_data = r_mvalid ? r_buf[r_rptr] : '0;

  // Round half up toward +inf, then clamp to the int16 range.
  assign w_t  = $signed({w_data[DW-1], w_data}) + HALF;
  assign w_sh = w_t >>> FB;

  always_comb begin
    w_int = w_sh[15:0];
    if (w_sh > IMAX)      w_int = 16'h7FFF;
    else if (w_sh < IMIN) w_int = 16'h8000;
  end

  assign bus.m_valid   = r_mvalid;
  assign bus.m_data    = w_data;
  assign bus.m_int     = w_int;
  assign bus.m_index   = r_rptr;
  assign bus.m_last    = r_mvalid && w_last;
  assign bus.frame_sum = r_sum;
  assign bus.busy      = r_busy;
  assign bus.overrun   = r_overrun;
endmodule

// File: tb/tb_gsim_result_drain.sv
// Directed bench for gsim_result_drain: fill/drain, rounding, stalls,
// input gaps, overrun and asynchronous reset.
module tb_gsim_result_drain;
  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic [31:0] fv [16];

  gsim_result_drain_if #(.DW(32), .IW(4)) bus ();

  gsim_result_drain #(.DEPTH(16), .DW(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [35:0] fsum();
    logic signed [35:0] s;
    s = '0;
    for (int k = 0; k < 16; k++) s = s + {{4{fv[k][31]}}, fv[k]};
    return s;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic fill(input int s, input int n);
    for (int k = s; k < s + n; k++) begin
      bus.x_valid = 1'b1;
      bus.x_in    = fv[k];
      step();
    end
    bus.x_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.x_valid = 1'b0; bus.x_in = '0; bus.m_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    step();
    total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL rst_m_valid got=%b exp=0", bus.m_valid); end
    total++; if (bus.m_data !== 32'h0) begin bad++; $display("FAIL rst_m_data got=%h exp=0", bus.m_data); end
    total++; if (bus.m_int !== 16'h0) begin bad++; $display("FAIL rst_m_int got=%h exp=0", bus.m_int); end
    total++; if (bus.m_index !== 4'h0) begin bad++; $display("FAIL rst_m_index got=%h exp=0", bus.m_index); end
    total++; if (bus.m_last !== 1'b0) begin bad++; $display("FAIL rst_m_last got=%b exp=0", bus.m_last); end
    total++; if (bus.frame_sum !== 36'h0) begin bad++; $display("FAIL rst_frame_sum got=%h exp=0", bus.frame_sum); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL rst_overrun got=%b exp=0", bus.overrun); end
  endtask

  task automatic test_full_frame();
    for (int k = 0; k < 16; k++) fv[k] = 32'(k) << 16;
    bus.m_ready = 1'b1;
    fill(0, 15);
    total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL ff_early_valid got=%b exp=0", bus.m_valid); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL ff_busy_fill got=%b exp=1", bus.busy); end
    fill(15, 1);
    for (int i = 0; i < 16; i++) begin
      total++; if (bus.m_valid !== 1'b1) begin bad++; $display("FAIL ff_valid[%0d] got=%b exp=1", i, bus.m_valid); end
      total++; if (bus.m_int !== 16'(i)) begin bad++; $display("FAIL ff_int[%0d] got=%0d exp=%0d", i, bus.m_int, i); end
      total++; if (bus.m_index !== 4'(i)) begin bad++; $display("FAIL ff_index[%0d] got=%0d exp=%0d", i, bus.m_index, i); end
      total++; if (bus.m_last !== (i == 15)) begin bad++; $display("FAIL ff_last[%0d] got=%b", i, bus.m_last); end
      step();
    end
    total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL ff_valid_end got=%b exp=0", bus.m_valid); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL ff_busy_end got=%b exp=0", bus.busy); end
    total++; if (bus.frame_sum !== 36'h0_0078_0000) begin bad++; $display("FAIL ff_sum got=%h exp=000780000", bus.frame_sum); end
  endtask

  task automatic test_rounding();
    logic [15:0] ei [16];
    fv = '{32'h0001_8000, 32'hFFFE_8000, 32'h0000_7FFF, 32'h7FFF_FFFF,
           32'h8000_0000, 32'hFFFF_8000, 32'h0000_8000, 32'hFFFF_7FFF,
           32'h7FFF_8000, 32'h8000_8000, 32'h0001_0000, 32'hFFFF_0000,
           32'h1234_0000, 32'hFFFF_FFFF, 32'h0002_7FFF, 32'hFFFF_8001};
    ei = '{16'd2, 16'hFFFF, 16'd0, 16'h7FFF, 16'h8000, 16'd0, 16'd1, 16'hFFFF,
           16'h7FFF, 16'h8001, 16'd1, 16'hFFFF, 16'h1234, 16'd0, 16'd2, 16'd0};
    bus.m_ready = 1'b1;
    fill(0, 16);
    total++; if (bus.frame_sum !== fsum()) begin bad++; $display("FAIL rnd_sum got=%h exp=%h", bus.frame_sum, fsum()); end
    for (int i = 0; i < 16; i++) begin
      total++; if (bus.m_data !== fv[i]) begin bad++; $display("FAIL rnd_data[%0d] got=%h exp=%h", i, bus.m_data, fv[i]); end
      total++; if (bus.m_int !== ei[i]) begin bad++; $display("FAIL rnd_int[%0d] got=%h exp=%h", i, bus.m_int, ei[i]); end
      step();
    end
  endtask

  task automatic test_backpressure();
    int idx, hs, stalls;
    for (int k = 0; k < 16; k++) fv[k] = (32'(k + 3) << 16) | 32'h1234;
    fill(0, 16);
    idx = 0; hs = 0; stalls = 0;
    for (int cyc = 0; cyc < 400 && hs < 16; cyc++) begin
      total++; if (bus.m_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d] got=%b exp=1", idx, bus.m_valid); end
      total++; if (bus.m_index !== 4'(idx)) begin bad++; $display("FAIL bp_index got=%0d exp=%0d", bus.m_index, idx); end
      total++; if (bus.m_data !== fv[idx]) begin bad++; $display("FAIL bp_data[%0d] got=%h exp=%h", idx, bus.m_data, fv[idx]); end
      total++; if (bus.m_int !== 16'(idx + 3)) begin bad++; $display("FAIL bp_int[%0d] got=%0d exp=%0d", idx, bus.m_int, idx + 3); end
      if (idx < 3) bus.m_ready = 1'b1;
      else if (idx == 3 && stalls < 5) begin bus.m_ready = 1'b0; stalls++; end
      else bus.m_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      if (bus.m_ready && bus.m_valid) begin hs++; idx++; end
      #1;
    end
    bus.m_ready = 1'b1;
    total++; if (hs !== 16) begin bad++; $display("FAIL bp_handshakes got=%0d exp=16", hs); end
    total++; if (stalls !== 5) begin bad++; $display("FAIL bp_stalls got=%0d exp=5", stalls); end
    total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL bp_valid_end got=%b exp=0", bus.m_valid); end
  endtask

  task automatic test_gaps();
    for (int k = 0; k < 16; k++) fv[k] = 32'hF000_0000 + 32'(k) * 32'h0101_0101;
    bus.m_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      for (int g = 0; g < k % 4; g++) begin
        bus.x_valid = 1'b0;
        step();
        total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL gap_valid[%0d] got=%b exp=0", k, bus.m_valid); end
      end
      fill(k, 1);
    end
    total++; if (bus.m_valid !== 1'b1) begin bad++; $display("FAIL gap_drain_start got=%b exp=1", bus.m_valid); end
    total++; if (bus.frame_sum !== fsum()) begin bad++; $display("FAIL gap_sum got=%h exp=%h", bus.frame_sum, fsum()); end
    for (int i = 0; i < 16; i++) begin
      total++; if (bus.m_data !== fv[i]) begin bad++; $display("FAIL gap_data[%0d] got=%h exp=%h", i, bus.m_data, fv[i]); end
      step();
    end
  endtask

  task automatic test_overrun();
    logic [35:0] s1;
    for (int k = 0; k < 16; k++) fv[k] = 32'h0000_4000 * 32'(k + 1);
    s1 = fsum();
    bus.m_ready = 1'b1;
    fill(0, 16);
    total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL ov_pre got=%b exp=0", bus.overrun); end
    for (int i = 0; i < 16; i++) begin
      total++; if (bus.m_data !== fv[i]) begin bad++; $display("FAIL ov_data[%0d] got=%h exp=%h", i, bus.m_data, fv[i]); end
      bus.x_valid = (i == 5 || i == 15);
      bus.x_in    = 32'hDEAD_BEEF;
      step();
      bus.x_valid = 1'b0;
    end
    total++; if (bus.overrun !== 1'b1) begin bad++; $display("FAIL ov_set got=%b exp=1", bus.overrun); end
    total++; if (bus.frame_sum !== s1) begin bad++; $display("FAIL ov_sum got=%h exp=%h", bus.frame_sum, s1); end
    total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL ov_idle got=%b exp=0", bus.m_valid); end
    for (int k = 0; k < 16; k++) fv[k] = 32'h8000_0000 + 32'(k);
    fill(0, 16);
    total++; if (bus.frame_sum !== fsum()) begin bad++; $display("FAIL ov_next_sum got=%h exp=%h", bus.frame_sum, fsum()); end
    for (int i = 0; i < 16; i++) begin
      total++; if (bus.m_data !== fv[i]) begin bad++; $display("FAIL ov_next_data[%0d] got=%h exp=%h", i, bus.m_data, fv[i]); end
      step();
    end
    total++; if (bus.overrun !== 1'b1) begin bad++; $display("FAIL ov_sticky got=%b exp=1", bus.overrun); end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 16; k++) fv[k] = 32'h0003_0000;
    bus.m_ready = 1'b1;
    fill(0, 7);
    #2 reset = 1'b1;
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL ar_fill_busy got=%b exp=0", bus.busy); end
    #2 reset = 1'b0;
    step();
    fill(0, 16);
    for (int i = 0; i < 9; i++) step();
    total++; if (bus.m_index !== 4'd9) begin bad++; $display("FAIL ar_pre_index got=%0d exp=9", bus.m_index); end
    #2 reset = 1'b1;
    #1;
    total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL ar_m_valid got=%b exp=0", bus.m_valid); end
    total++; if (bus.m_data !== 32'h0) begin bad++; $display("FAIL ar_m_data got=%h exp=0", bus.m_data); end
    total++; if (bus.m_int !== 16'h0) begin bad++; $display("FAIL ar_m_int got=%h exp=0", bus.m_int); end
    total++; if (bus.m_index !== 4'h0) begin bad++; $display("FAIL ar_m_index got=%h exp=0", bus.m_index); end
    total++; if (bus.m_last !== 1'b0) begin bad++; $display("FAIL ar_m_last got=%b exp=0", bus.m_last); end
    total++; if (bus.frame_sum !== 36'h0) begin bad++; $display("FAIL ar_frame_sum got=%h exp=0", bus.frame_sum); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL ar_busy got=%b exp=0", bus.busy); end
    total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL ar_overrun got=%b exp=0", bus.overrun); end
    #2 reset = 1'b0;
    step();
    for (int k = 0; k < 16; k++) fv[k] = 32'hFFFF_0000 - (32'(k) << 12);
    fill(0, 16);
    total++; if (bus.frame_sum !== fsum()) begin bad++; $display("FAIL ar_new_sum got=%h exp=%h", bus.frame_sum, fsum()); end
    for (int i = 0; i < 16; i++) begin
      total++; if (bus.m_data !== fv[i]) begin bad++; $display("FAIL ar_new_data[%0d] got=%h exp=%h", i, bus.m_data, fv[i]); end
      total++; if (bus.m_index !== 4'(i)) begin bad++; $display("FAIL ar_new_index got=%0d exp=%0d", bus.m_index, i); end
      step();
    end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL ar_new_busy got=%b exp=0", bus.busy); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_full_frame();
    test_rounding();
    test_backpressure();
    test_gaps();
    test_overrun();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gsim_result_drain.md
Name: gsim_result_drain

Overview:
- Downstream stage of the Gauss-Seidel iteration machine.
- Captures the 16-word solution burst (x_out qualified by out_valid) into a frame buffer.
- Re-issues the frame on a valid/ready stream with backpressure. Each word is sent both as raw signed Q16.16 and as a rounded, saturated 16-bit integer.
- Produces a per-frame signed sum and a sticky overrun flag for the system controller.

Parameters:
- DEPTH, 16, words per frame; must be a power of two; index width IW = log2(DEPTH).
- DW, 32, input word width; signed Q16.16.
- SW, DW+IW (36), frame sum width.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous, active-high; clears all state.
- x_valid, input, 1, input word qualifier (driven by the solver's out_valid).
- x_in, input, DW, solution word, signed Q16.16.
- m_valid, output, 1, output word available.
- m_ready, input, 1, consumer accepts the word when m_valid and m_ready are both high.
- m_data, output, DW, raw buffered word.
- m_int, output, 16, rounded and saturated integer of m_data.
- m_index, output, IW, position of the word in the frame (0..DEPTH-1).
- m_last, output, 1, high with the word at index DEPTH-1.
- frame_sum, output, SW, signed sum of all DEPTH words of the current frame; stable throughout DRAIN.
- busy, output, 1, high in FILL or DRAIN.
- overrun, output, 1, sticky; set when an input word is dropped.

Behaviour:
- Reset values: m_valid=0, m_data=0, m_int=0, m_index=0, m_last=0, frame_sum=0, busy=0, overrun=0. State=IDLE, write count=0, read pointer=0.
- Reset asserted mid-frame or mid-drain aborts the frame immediately. Buffer contents are don't-care afterwards.
- The state machine has three states: IDLE, FILL, DRAIN.
- IDLE:
  - x_valid=1 writes x_in to buffer[0], sets the write count to 1, loads the sum accumulator with the sign-extended x_in, and moves to FILL.
  - If DEPTH were 1 the block would go straight to DRAIN; DEPTH=1 is not supported.
- FILL:
  - Each cycle with x_valid=1 writes buffer[wcnt], increments wcnt and adds the sign-extended x_in to the accumulator.
  - Cycles with x_valid=0 hold all state; gaps are legal and there is no timeout.
  - The write that takes wcnt to DEPTH moves to DRAIN. On that same edge frame_sum is loaded with the final sum and the read pointer is set to 0.
- DRAIN:
  - m_valid=1. m_data=buffer[rptr], m_index=rptr, m_last=(rptr==DEPTH-1).
  - First m_valid is the cycle after the DEPTH-th input word is captured (1-cycle capture-to-output latency).
  - Outputs are held stable while m_valid=1 and m_ready=0.
  - A handshake increments rptr.
  - A handshake on m_last returns to IDLE: m_valid=0 on the next cycle and frame_sum holds its value.
  - Throughput is one word per cycle when m_ready stays high, so a full drain takes DEPTH cycles.
- Overrun:
  - x_valid=1 while in DRAIN drops the word and sets overrun to 1.
  - The drain continues unaffected; overrun clears only on reset.
- Hand-off at the end of DRAIN: x_valid=1 on the same cycle as the m_last handshake also counts as dropped, because the state is still DRAIN on that cycle. The next frame's first word must arrive no earlier than the following cycle.
- m_int arithmetic (combinational from m_data):
  - t = sign-extend(m_data) to 33 bits + 0x8000, then arithmetic shift right by 16. This is round-half-up toward +infinity.
  - Saturate t to [-32768, 32767].
- frame_sum:
  - Exact; no overflow is possible at SW = DW+IW.
  - Two's-complement, sign-extended accumulation.
- busy = (state != IDLE).

Test Plan:
- Full frame, m_ready held at 1:
  - Stimulus: 16 consecutive x_valid words, x_in = k<<16 for k = 0..15.
  - Required: m_valid rises one cycle after the 16th word.
  - Required: m_int reads 0..15 on consecutive cycles, m_index matches, and m_last is high only at index 15.
  - Required: frame_sum = 0x0_0078_0000 (120.0); busy drops after the last handshake.
- Rounding and saturation:
  - 0x0001_8000 -> m_int = 2.
  - 0xFFFE_8000 -> m_int = -1.
  - 0x0000_7FFF -> m_int = 0.
  - 0x7FFF_FFFF -> m_int = 32767.
  - 0x8000_0000 -> m_int = -32768.
  - 0xFFFF_8000 -> m_int = 0.
- Backpressure:
  - Stimulus: m_ready=0 for 5 cycles at index 3, plus random m_ready thereafter.
  - Required: m_data, m_int and m_index are held through each stall.
  - Required: no word is lost or duplicated, and exactly 16 handshakes occur.
- Input gaps:
  - Stimulus: the 16 words are interleaved with 0-3 idle cycles of x_valid=0.
  - Required: the captured order is preserved, and DRAIN starts one cycle after the 16th valid word.
- Overrun:
  - Stimulus: x_valid pulsed during DRAIN, including on the m_last handshake cycle.
  - Required: overrun is 1 and stays 1; the drained frame is unchanged.
  - Required: a new frame starting on the cycle after the m_last handshake is captured correctly.
- Asynchronous reset mid-operation:
  - Stimulus: reset asserted between clock edges, once during FILL at wcnt=7 and once during DRAIN at rptr=9.
  - Required: all outputs go to their reset values immediately.
  - Required: a fresh 16-word frame after reset drains correctly, with frame_sum computed from the new words only.
